// File: rtl/kem_keccak_arbiter_if.sv
// Request/grant bus between the ML-KEM sequencers and the Keccak core arbiter.
// slave = arbiter side, master = requesters plus Keccak core side.
interface kem_keccak_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int MODE_W  = 2
);
  logic [NUM_REQ-1:0]         req_i;
  logic [NUM_REQ*MODE_W-1:0]  mode_i;
  logic [NUM_REQ-1:0]         gnt_o;
  logic [NUM_REQ-1:0]         done_o;
  logic [NUM_REQ-1:0]         err_o;
  logic                       busy_o;
  logic [$clog2(NUM_REQ)-1:0] owner_o;
  logic                       core_start_o;
  logic [MODE_W-1:0]          core_mode_o;
  logic                       core_abort_o;
  logic                       core_done_i;

  modport slave (
    input  req_i, mode_i, core_done_i,
    output gnt_o, done_o, err_o, busy_o, owner_o,
           core_start_o, core_mode_o, core_abort_o
  );

  modport master (
    output req_i, mode_i, core_done_i,
    input  gnt_o, done_o, err_o, busy_o, owner_o,
           core_start_o, core_mode_o, core_abort_o
  );
endinterface

// File: rtl/kem_keccak_arbiter.sv
// Round-robin owner of the shared Keccak core: one locked grant per hash job,
// completion routed to the owner only, watchdog abort for hung jobs.
module kem_keccak_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MODE_W      = 2,
  parameter int TIMEOUT_CYC = 4095,
  parameter int CNT_W       = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  kem_keccak_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam bit WD_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_RELEASE
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [CNT_W-1:0]   wd_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] err_q;
  logic               busy_q;
  logic               start_q;
  logic               abort_q;
  logic [MODE_W-1:0]  mode_q;

  logic               win_vld_d;
  logic [IDX_W-1:0]   win_d;
  logic [MODE_W-1:0]  win_mode_d;
  logic               owner_req_d;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Scan from the farthest candidate back to ptr+1 so the nearest asserted
  // request after the last owner is the one that sticks.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_vld_d = 1'b0;
    win_d     = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(ptr_q) + off) % NUM_REQ);
      if (bus.req_i[cand]) begin
        win_vld_d = 1'b1;
        win_d     = cand;
      end
    end
  end

  always_comb begin
    win_mode_d = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (win_d == IDX_W'(r)) begin
        win_mode_d = bus.mode_i[r*MODE_W +: MODE_W];
      end
    end
  end

  assign owner_req_d = bus.req_i[owner_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      wd_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      mode_q  <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      abort_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            owner_q <= win_d;
            mode_q  <= win_mode_d;
            gnt_q   <= onehot(win_d);
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          wd_q    <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          wd_q <= wd_q + CNT_W'(1);
          // A completion in the same cycle as a withdraw or timeout still counts as done.
          if (bus.core_done_i) begin
            done_q  <= onehot(owner_q);
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_RELEASE;
          end else if (!owner_req_d) begin
            abort_q <= 1'b1;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_RELEASE;
          end else if (WD_EN && (wd_q == WD_LAST)) begin
            abort_q <= 1'b1;
            err_q   <= onehot(owner_q);
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          ptr_q   <= owner_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt_o        = gnt_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
  assign bus.busy_o       = busy_q;
  assign bus.owner_o      = owner_q;
  assign bus.core_start_o = start_q;
  assign bus.core_mode_o  = mode_q;
  assign bus.core_abort_o = abort_q;

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_q));
  a_start_busy  : assert property (@(posedge clk_i) disable iff (rst_i) start_q |-> busy_q);

endmodule

// File: tb/tb_kem_keccak_arbiter.sv
// Bench for kem_keccak_arbiter: vector table, directed corner sequences and a
// randomized job-level round-robin model.
module tb_kem_keccak_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  kem_keccak_arbiter_if #(.NUM_REQ(N), .MODE_W(2)) bus ();
  kem_keccak_arbiter_if #(.NUM_REQ(N), .MODE_W(2)) wbus ();

  kem_keccak_arbiter #(.NUM_REQ(N), .MODE_W(2), .TIMEOUT_CYC(4095), .CNT_W(12)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  kem_keccak_arbiter #(.NUM_REQ(N), .MODE_W(2), .TIMEOUT_CYC(16), .CNT_W(5)) dut_wd (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (wbus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=stuck required=finish");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic [3:0] req;
    logic [7:0] mode;
    int         own;
    logic [1:0] md;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  task automatic do_reset();
    rst              = 1'b1;
    bus.req_i        = '0;
    bus.core_done_i  = 1'b0;
    wbus.req_i       = '0;
    wbus.core_done_i = 1'b0;
    tick();
    tick();
    chk("reset_main", {bus.gnt_o, bus.done_o, bus.err_o, bus.busy_o, bus.owner_o,
                       bus.core_start_o, bus.core_mode_o, bus.core_abort_o}, 32'h0);
    chk("reset_wd", {wbus.gnt_o, wbus.done_o, wbus.err_o, wbus.busy_o, wbus.owner_o,
                     wbus.core_start_o, wbus.core_mode_o, wbus.core_abort_o}, 32'h0);
    rst = 1'b0;
  endtask

  task automatic grant_chk(input int ew, input logic [1:0] md, input string tag);
    tick();
    chk({tag, ".grant"}, {bus.gnt_o, bus.core_start_o, bus.busy_o, bus.owner_o, bus.core_mode_o},
        {oh(ew), 1'b1, 1'b1, 2'(ew), md});
  endtask

  task automatic run_chk(input int ew, input logic [1:0] md, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, ".run"}, {bus.gnt_o, bus.core_start_o, bus.busy_o, bus.core_abort_o,
                          bus.done_o, bus.err_o, bus.core_mode_o},
          {oh(ew), 1'b0, 1'b1, 1'b0, 4'b0, 4'b0, md});
    end
  endtask

  // dm: 0 keep request, 1 drop together with core_done_i, 2 drop after done_o
  task automatic finish_chk(input int ew, input int dm, input string tag);
    bus.core_done_i = 1'b1;
    if (dm == 1) bus.req_i[ew] = 1'b0;
    tick();
    bus.core_done_i = 1'b0;
    chk({tag, ".done"}, {bus.done_o, bus.gnt_o, bus.busy_o, bus.core_abort_o, bus.err_o},
        {oh(ew), 4'b0, 1'b0, 1'b0, 4'b0});
    if (dm == 2) bus.req_i[ew] = 1'b0;
    tick();
    chk({tag, ".rel"}, {bus.done_o, bus.gnt_o, bus.busy_o, bus.core_abort_o, bus.err_o,
                        bus.core_start_o, bus.owner_o},
        {4'b0, 4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 2'(ew)});
  endtask

  task automatic serve(input int ew, input logic [1:0] md, input int n, input int dm, input string tag);
    grant_chk(ew, md, tag);
    run_chk(ew, md, n, tag);
    finish_chk(ew, dm, tag);
  endtask

  initial begin
    int seen;
    logic [3:0] err_seen, gnt_seen, done_seen;
    int last, ew, n, kind;
    logic [3:0] r;
    logic [7:0] m;
    logic [1:0] md;

    vecs[0]  = '{4'b0001, 8'hD2, 0, 2'd2};
    vecs[1]  = '{4'b1111, 8'h1B, 1, 2'd2};
    vecs[2]  = '{4'b1111, 8'hD2, 2, 2'd1};
    vecs[3]  = '{4'b1111, 8'h1B, 3, 2'd0};
    vecs[4]  = '{4'b0101, 8'hD2, 0, 2'd2};
    vecs[5]  = '{4'b0101, 8'h1B, 2, 2'd1};
    vecs[6]  = '{4'b0011, 8'h1B, 0, 2'd3};
    vecs[7]  = '{4'b1000, 8'hD2, 3, 2'd3};
    vecs[8]  = '{4'b1000, 8'h1B, 3, 2'd0};
    vecs[9]  = '{4'b0110, 8'hD2, 1, 2'd0};
    vecs[10] = '{4'b1001, 8'h1B, 3, 2'd0};
    vecs[11] = '{4'b0010, 8'h1B, 1, 2'd2};

    bus.mode_i  = '0;
    wbus.mode_i = '0;
    do_reset();

    // Single requester, long job, mode SHAKE128
    bus.req_i  = 4'b0001;
    bus.mode_i = 8'h02;
    serve(0, 2'd2, 24, 2, "t1");

    // Vector table; each job leaves the pointer at its owner
    for (int i = 0; i < 12; i++) begin
      bus.req_i  = vecs[i].req;
      bus.mode_i = vecs[i].mode;
      serve(vecs[i].own, vecs[i].md, 1 + (i % 3), 0, $sformatf("vec%0d", i));
    end

    // All four requesting straight out of reset, then re-request by 0 and 2
    do_reset();
    bus.req_i  = 4'b1111;
    bus.mode_i = 8'hD2;
    serve(0, 2'd2, 2, 2, "t2a");
    serve(1, 2'd0, 3, 2, "t2b");
    serve(2, 2'd1, 1, 2, "t2c");
    serve(3, 2'd3, 2, 2, "t2d");
    bus.req_i = 4'b0101;
    serve(0, 2'd2, 2, 2, "t2e");
    serve(2, 2'd1, 2, 2, "t2f");

    // Owner 2 withdraws mid-job; pending requester 3 follows three cycles later
    do_reset();
    bus.req_i  = 4'b1100;
    bus.mode_i = 8'h90;
    grant_chk(2, 2'd1, "t3");
    run_chk(2, 2'd1, 3, "t3");
    bus.req_i[2] = 1'b0;
    tick();
    chk("t3.abort", {bus.core_abort_o, bus.done_o, bus.err_o, bus.gnt_o, bus.busy_o},
        {1'b1, 4'b0, 4'b0, 4'b0, 1'b0});
    tick();
    chk("t3.gap", {bus.core_abort_o, bus.gnt_o, bus.busy_o}, 9'h0);
    grant_chk(3, 2'd2, "t3n");
    run_chk(3, 2'd2, 2, "t3n");
    finish_chk(3, 2, "t3n");

    // Done and withdraw in the same cycle, then a stray done while idle
    bus.req_i  = 4'b0001;
    bus.mode_i = 8'hD2;
    grant_chk(0, 2'd2, "t6");
    run_chk(0, 2'd2, 2, "t6");
    finish_chk(0, 1, "t6");
    bus.core_done_i = 1'b1;
    tick();
    bus.core_done_i = 1'b0;
    chk("t6.idle_done", {bus.done_o, bus.gnt_o, bus.busy_o, bus.core_start_o}, 10'h0);
    tick();
    chk("t6.idle_after", {bus.done_o, bus.gnt_o, bus.busy_o, bus.core_start_o}, 10'h0);

    // Asynchronous reset in the middle of a job
    bus.req_i = 4'b1000;
    grant_chk(3, 2'd3, "t5");
    run_chk(3, 2'd3, 2, "t5");
    #2;
    rst = 1'b1;
    #1;
    chk("t5.async", {bus.gnt_o, bus.busy_o, bus.core_start_o, bus.core_mode_o,
                     bus.core_abort_o, bus.done_o, bus.err_o, bus.owner_o}, 32'h0);
    tick();
    rst       = 1'b0;
    bus.req_i = 4'b1001;
    grant_chk(0, 2'd2, "t5r");
    run_chk(0, 2'd2, 1, "t5r");
    finish_chk(0, 2, "t5r");
    bus.req_i = 4'b0000;
    tick();

    // Watchdog with a 16-cycle limit on the second instance
    wbus.req_i  = 4'b1010;
    wbus.mode_i = 8'h4C;
    tick();
    chk("t4.grant", {wbus.gnt_o, wbus.core_start_o, wbus.core_mode_o}, {4'b0010, 1'b1, 2'd3});
    tick();
    seen      = -1;
    err_seen  = '0;
    gnt_seen  = '1;
    done_seen = '1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (wbus.core_abort_o) begin
        seen      = i;
        err_seen  = wbus.err_o;
        gnt_seen  = wbus.gnt_o;
        done_seen = wbus.done_o;
        break;
      end
    end
    chk("t4.abort_cycle", seen, 16);
    chk("t4.err", {err_seen, gnt_seen, done_seen}, {4'b0010, 4'b0, 4'b0});
    tick();
    chk("t4.clear", {wbus.core_abort_o, wbus.err_o, wbus.gnt_o}, 9'h0);
    tick();
    chk("t4.next", {wbus.gnt_o, wbus.core_start_o, wbus.core_mode_o}, {4'b1000, 1'b1, 2'd1});
    tick();
    wbus.core_done_i = 1'b1;
    tick();
    wbus.core_done_i = 1'b0;
    chk("t4.next_done", {wbus.done_o, wbus.err_o, wbus.core_abort_o}, {4'b1000, 4'b0, 1'b0});
    wbus.req_i = 4'b0000;
    tick();

    // Randomized jobs against a round-robin job model
    do_reset();
    last = N - 1;
    for (int j = 0; j < 150; j++) begin
      r = 4'($urandom_range(1, 15));
      m = 8'($urandom);
      bus.req_i  = r;
      bus.mode_i = m;
      ew = -1;
      for (int k = 1; k <= N; k++) begin
        if (ew < 0 && r[(last + k) % N]) ew = (last + k) % N;
      end
      md = m[2*ew +: 2];
      grant_chk(ew, md, "rnd");
      n = $urandom_range(1, 6);
      for (int c = 0; c < n; c++) begin
        bus.req_i     = 4'($urandom);
        bus.req_i[ew] = 1'b1;
        bus.mode_i    = 8'($urandom);
        tick();
        chk("rnd.run", {bus.gnt_o, bus.core_start_o, bus.busy_o, bus.core_abort_o,
                        bus.done_o, bus.core_mode_o},
            {oh(ew), 1'b0, 1'b1, 1'b0, 4'b0, md});
      end
      kind = $urandom_range(0, 2);
      if (kind == 2) begin
        bus.req_i[ew] = 1'b0;
        tick();
        chk("rnd.withdraw", {bus.core_abort_o, bus.done_o, bus.err_o, bus.gnt_o, bus.busy_o},
            {1'b1, 4'b0, 4'b0, 4'b0, 1'b0});
        tick();
        chk("rnd.wrel", {bus.core_abort_o, bus.gnt_o, bus.owner_o}, {1'b0, 4'b0, 2'(ew)});
      end else begin
        finish_chk(ew, kind, "rnd");
      end
      last = ew;
      if ($urandom_range(0, 3) == 0) begin
        bus.req_i       = 4'b0000;
        bus.core_done_i = 1'b1;
        tick();
        bus.core_done_i = 1'b0;
        chk("rnd.idle_done", {bus.done_o, bus.gnt_o, bus.busy_o}, 9'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
